// File: rtl/core_pkg.sv
// core_pkg: shared widths and the write-request type used by both
// register-file write sources (WB stage and long-latency unit).
package core_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned XLEN       = 32;

   // One register-file write: destination register plus data.
   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_req_t;

   // Which source owns the register-file write port this cycle.
   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_WB   = 2'd1,
      SRC_LU   = 2'd2
   } wr_src_t;

endpackage

// File: rtl/lu_result_fifo.sv
// lu_result_fifo: buffer for long-latency results waiting for the
// register-file write port.
//   clk, reset  : clock, asynchronous active-low reset
//   push        : accept push_req this cycle (caller guarantees !full)
//   push_req    : {rd, data} to enqueue
//   pop         : drop the head entry this cycle (caller guarantees !empty)
//   head        : oldest entry; only meaningful while !empty
//   empty, full : occupancy flags from registered state
// A push is visible at head no earlier than the following cycle.
module lu_result_fifo
   import core_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic    clk,
   input  logic    reset,
   input  logic    push,
   input  wb_req_t push_req,
   input  logic    pop,
   output wb_req_t head,
   output logic    empty,
   output logic    full
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   wb_req_t       mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_req;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched: write-port scheduler and scoreboard for the integer
// register file. Merges in-order WB results with buffered long-latency
// results onto one write port and produces the ID hazard stall.
//   wb_valid/wb_rd/wb_data, wb_stall         : WB-stage write source
//   lu_issue/lu_issue_rd                     : long-latency issue (sets pending)
//   lu_res_valid/rd/data, lu_res_ready       : long-latency result offer
//   id_rs1/id_rs2/id_rd, hazard_stall        : ID-stage hazard check
//   rf_we/rf_rd/rf_wdata                     : register-file write port
//   sb_err                                   : sticky protocol-violation flag
module regfile_wb_sched
   import core_pkg::*;
#(
   parameter int unsigned LU_BUF_DEPTH = 2,
   parameter int unsigned STARVE_MAX   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wb_valid,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic [XLEN-1:0]       wb_data,
   output logic                  wb_stall,
   input  logic                  lu_issue,
   input  logic [REG_ADDR_W-1:0] lu_issue_rd,
   input  logic                  lu_res_valid,
   input  logic [REG_ADDR_W-1:0] lu_res_rd,
   input  logic [XLEN-1:0]       lu_res_data,
   output logic                  lu_res_ready,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   output logic                  hazard_stall,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_rd,
   output logic [XLEN-1:0]       rf_wdata,
   output logic                  sb_err
);

   localparam int unsigned SW = $clog2(STARVE_MAX + 1);

   logic [31:1]   pending;
   logic [31:1]   pending_nxt;
   logic [31:0]   pend_vec;
   logic [SW-1:0] starve_cnt;
   wr_src_t       src;
   wb_req_t       head;
   wb_req_t       sel;
   logic          buf_empty;
   logic          buf_full;
   logic          push;
   logic          pop;
   logic          forced;
   logic          err_now;

   lu_result_fifo #(.DEPTH(LU_BUF_DEPTH)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .push_req ('{rd: lu_res_rd, data: lu_res_data}),
      .pop      (pop),
      .head     (head),
      .empty    (buf_empty),
      .full     (buf_full)
   );

   // Bit 0 is a constant zero so an index of x0 never reports pending.
   assign pend_vec     = {pending, 1'b0};
   assign hazard_stall = pend_vec[id_rs1] | pend_vec[id_rs2] | pend_vec[id_rd];

   assign lu_res_ready = !buf_full;
   assign push         = lu_res_valid && lu_res_ready;
   assign forced       = !buf_empty && (starve_cnt == SW'(STARVE_MAX));

   always_comb begin
      src = SRC_NONE;
      if (forced)          src = SRC_LU;
      else if (wb_valid)   src = SRC_WB;
      else if (!buf_empty) src = SRC_LU;
   end

   assign pop      = (src == SRC_LU);
   assign wb_stall = wb_valid && (src != SRC_WB);
   assign sel      = pop ? head : '{rd: wb_rd, data: wb_data};
   assign rf_we    = (src != SRC_NONE) && (sel.rd != '0);
   assign rf_rd    = sel.rd;
   assign rf_wdata = sel.data;

   // Issue is applied after the clear so a same-cycle set wins.
   always_comb begin
      pending_nxt = pending;
      for (int unsigned r = 1; r < 32; r++) begin
         if (pop && head.rd == REG_ADDR_W'(r))        pending_nxt[r] = 1'b0;
         if (lu_issue && lu_issue_rd == REG_ADDR_W'(r)) pending_nxt[r] = 1'b1;
      end
   end

   assign err_now = (lu_issue && hazard_stall)
                 || (wb_valid && pend_vec[wb_rd] && !wb_stall)
                 || (push && !pend_vec[lu_res_rd]);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending    <= '0;
         starve_cnt <= '0;
         sb_err     <= 1'b0;
      end else begin
         pending <= pending_nxt;
         if (buf_empty || pop)                   starve_cnt <= '0;
         else if (starve_cnt != SW'(STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;
         if (err_now) sb_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_regfile_wb_sched.sv
module tb_regfile_wb_sched;

   logic        clk;
   logic        reset;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_stall;
   logic        lu_issue;
   logic [4:0]  lu_issue_rd;
   logic        lu_res_valid;
   logic [4:0]  lu_res_rd;
   logic [31:0] lu_res_data;
   logic        lu_res_ready;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic [4:0]  id_rd;
   logic        hazard_stall;
   logic        rf_we;
   logic [4:0]  rf_rd;
   logic [31:0] rf_wdata;
   logic        sb_err;

   int tests_run = 0;
   int tests_failed = 0;

   regfile_wb_sched #(.LU_BUF_DEPTH(2), .STARVE_MAX(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .wb_valid     (wb_valid),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .wb_stall     (wb_stall),
      .lu_issue     (lu_issue),
      .lu_issue_rd  (lu_issue_rd),
      .lu_res_valid (lu_res_valid),
      .lu_res_rd    (lu_res_rd),
      .lu_res_data  (lu_res_data),
      .lu_res_ready (lu_res_ready),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_rd        (id_rd),
      .hazard_stall (hazard_stall),
      .rf_we        (rf_we),
      .rf_rd        (rf_rd),
      .rf_wdata     (rf_wdata),
      .sb_err       (sb_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change just after the falling edge; outputs are sampled 1ns later.
   task automatic next_cycle();
      @(negedge clk);
      wb_valid     = 1'b0;
      wb_rd        = '0;
      wb_data      = '0;
      lu_issue     = 1'b0;
      lu_issue_rd  = '0;
      lu_res_valid = 1'b0;
      lu_res_rd    = '0;
      lu_res_data  = '0;
      id_rs1       = '0;
      id_rs2       = '0;
      id_rd        = '0;
   endtask

   task automatic do_reset();
      next_cycle();
      reset = 1'b0;
      next_cycle();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b0; wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h55;
      #1;
      tests_run++;
      if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_wdata !== 32'h55) begin
         tests_failed++;
         $display("FAIL reset_wb_path: got we=%b rd=%0d data=%h exp we=1 rd=5 data=00000055", rf_we, rf_rd, rf_wdata);
      end
      tests_run++;
      if (hazard_stall !== 1'b0 || lu_res_ready !== 1'b1 || sb_err !== 1'b0 || wb_stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_state: got haz=%b ready=%b err=%b wbst=%b exp 0 1 0 0", hazard_stall, lu_res_ready, sb_err, wb_stall);
      end
      next_cycle();
      reset = 1'b1;
   endtask

   task automatic test_basic_lu();
      next_cycle(); lu_issue = 1'b1; lu_issue_rd = 5'd7;
      next_cycle(); id_rs1 = 5'd7;
      lu_res_valid = 1'b1; lu_res_rd = 5'd7; lu_res_data = 32'hDEADBEEF;
      #1;
      tests_run++;
      if (hazard_stall !== 1'b1) begin
         tests_failed++;
         $display("FAIL basic_hazard_set: got %b exp 1", hazard_stall);
      end
      tests_run++;
      if (rf_we !== 1'b0 || lu_res_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL basic_no_bypass: got we=%b ready=%b exp we=0 ready=1", rf_we, lu_res_ready);
      end
      next_cycle(); id_rs1 = 5'd7;
      #1;
      tests_run++;
      if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_wdata !== 32'hDEADBEEF) begin
         tests_failed++;
         $display("FAIL basic_lu_write: got we=%b rd=%0d data=%h exp we=1 rd=7 data=deadbeef", rf_we, rf_rd, rf_wdata);
      end
      next_cycle(); id_rs1 = 5'd7;
      #1;
      tests_run++;
      if (hazard_stall !== 1'b0 || rf_we !== 1'b0 || sb_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_hazard_clear: got haz=%b we=%b err=%b exp 0 0 0", hazard_stall, rf_we, sb_err);
      end
   endtask

   task automatic test_starvation();
      next_cycle(); lu_issue = 1'b1; lu_issue_rd = 5'd3;
      next_cycle();
      lu_res_valid = 1'b1; lu_res_rd = 5'd3; lu_res_data = 32'h11;
      wb_valid = 1'b1; wb_rd = 5'd10; wb_data = 32'hA0;
      #1;
      tests_run++;
      if (rf_we !== 1'b1 || rf_rd !== 5'd10 || wb_stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL starve_push_cycle: got we=%b rd=%0d wbst=%b exp 1 10 0", rf_we, rf_rd, wb_stall);
      end
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         wb_valid = 1'b1; wb_rd = 5'd10; wb_data = 32'hB0 + 32'(i);
         #1;
         tests_run++;
         if (rf_rd !== 5'd10 || rf_wdata !== 32'hB0 + 32'(i) || wb_stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL starve_wb_%0d: got rd=%0d data=%h wbst=%b exp rd=10 data=%h wbst=0", i, rf_rd, rf_wdata, wb_stall, 32'hB0 + 32'(i));
         end
      end
      next_cycle();
      wb_valid = 1'b1; wb_rd = 5'd10; wb_data = 32'hC0;
      #1;
      tests_run++;
      if (rf_we !== 1'b1 || rf_rd !== 5'd3 || rf_wdata !== 32'h11 || wb_stall !== 1'b1) begin
         tests_failed++;
         $display("FAIL starve_forced: got we=%b rd=%0d data=%h wbst=%b exp 1 3 00000011 1", rf_we, rf_rd, rf_wdata, wb_stall);
      end
      next_cycle();
      wb_valid = 1'b1; wb_rd = 5'd10; wb_data = 32'hC0;
      #1;
      tests_run++;
      if (rf_we !== 1'b1 || rf_rd !== 5'd10 || rf_wdata !== 32'hC0 || wb_stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL starve_represent: got we=%b rd=%0d data=%h wbst=%b exp 1 10 000000c0 0", rf_we, rf_rd, rf_wdata, wb_stall);
      end
      next_cycle();
      #1;
      tests_run++;
      if (rf_we !== 1'b0 || sb_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL starve_idle: got we=%b err=%b exp 0 0", rf_we, sb_err);
      end
   endtask

   task automatic test_full_buffer();
      next_cycle(); lu_issue = 1'b1; lu_issue_rd = 5'd1;
      next_cycle(); lu_issue = 1'b1; lu_issue_rd = 5'd2;
      next_cycle(); lu_issue = 1'b1; lu_issue_rd = 5'd12;
      next_cycle();
      wb_valid = 1'b1; wb_rd = 5'd11; wb_data = 32'h1;
      lu_res_valid = 1'b1; lu_res_rd = 5'd1; lu_res_data = 32'h101;
      next_cycle();
      wb_valid = 1'b1; wb_rd = 5'd11; wb_data = 32'h2;
      lu_res_valid = 1'b1; lu_res_rd = 5'd2; lu_res_data = 32'h202;
      #1;
      tests_run++;
      if (lu_res_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL full_second_push_ready: got %b exp 1", lu_res_ready);
      end
      next_cycle();
      wb_valid = 1'b1; wb_rd = 5'd11; wb_data = 32'h3;
      lu_res_valid = 1'b1; lu_res_rd = 5'd12; lu_res_data = 32'h303;
      #1;
      tests_run++;
      if (lu_res_ready !== 1'b0 || rf_rd !== 5'd11 || wb_stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL full_not_ready: got ready=%b rd=%0d wbst=%b exp 0 11 0", lu_res_ready, rf_rd, wb_stall);
      end
      next_cycle();
      lu_res_valid = 1'b1; lu_res_rd = 5'd12; lu_res_data = 32'h303;
      #1;
      tests_run++;
      if (lu_res_ready !== 1'b0 || rf_we !== 1'b1 || rf_rd !== 5'd1 || rf_wdata !== 32'h101) begin
         tests_failed++;
         $display("FAIL full_pop_first: got ready=%b we=%b rd=%0d data=%h exp 0 1 1 00000101", lu_res_ready, rf_we, rf_rd, rf_wdata);
      end
      next_cycle();
      lu_res_valid = 1'b1; lu_res_rd = 5'd12; lu_res_data = 32'h303;
      #1;
      tests_run++;
      if (lu_res_ready !== 1'b1 || rf_rd !== 5'd2 || rf_wdata !== 32'h202) begin
         tests_failed++;
         $display("FAIL full_pop_second: got ready=%b rd=%0d data=%h exp 1 2 00000202", lu_res_ready, rf_rd, rf_wdata);
      end
      next_cycle();
      id_rs2 = 5'd12;
      #1;
      tests_run++;
      if (rf_we !== 1'b1 || rf_rd !== 5'd12 || rf_wdata !== 32'h303 || hazard_stall !== 1'b1) begin
         tests_failed++;
         $display("FAIL full_held_offer: got we=%b rd=%0d data=%h haz=%b exp 1 12 00000303 1", rf_we, rf_rd, rf_wdata, hazard_stall);
      end
      next_cycle();
      id_rs2 = 5'd12;
      #1;
      tests_run++;
      if (rf_we !== 1'b0 || hazard_stall !== 1'b0 || sb_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL full_drained: got we=%b haz=%b err=%b exp 0 0 0", rf_we, hazard_stall, sb_err);
      end
   endtask

   task automatic test_x0_set_wins();
      next_cycle(); lu_issue = 1'b1; lu_issue_rd = 5'd9;
      next_cycle();
      lu_res_valid = 1'b1; lu_res_rd = 5'd9; lu_res_data = 32'h99;
      next_cycle(); lu_issue = 1'b1; lu_issue_rd = 5'd9;
      #1;
      tests_run++;
      if (rf_we !== 1'b1 || rf_rd !== 5'd9) begin
         tests_failed++;
         $display("FAIL setwins_pop: got we=%b rd=%0d exp 1 9", rf_we, rf_rd);
      end
      next_cycle(); id_rd = 5'd9;
      #1;
      tests_run++;
      if (hazard_stall !== 1'b1 || sb_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL setwins_pending: got haz=%b err=%b exp 1 0", hazard_stall, sb_err);
      end
      next_cycle(); lu_issue = 1'b1; lu_issue_rd = 5'd0;
      next_cycle();
      lu_res_valid = 1'b1; lu_res_rd = 5'd0; lu_res_data = 32'hABC;
      next_cycle();
      #1;
      tests_run++;
      if (rf_we !== 1'b0 || rf_rd !== 5'd0 || sb_err !== 1'b1) begin
         tests_failed++;
         $display("FAIL x0_pop_no_write: got we=%b rd=%0d err=%b exp 0 0 1", rf_we, rf_rd, sb_err);
      end
      next_cycle();
      wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h5;
      #1;
      tests_run++;
      if (rf_we !== 1'b0 || wb_stall !== 1'b0 || lu_res_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL x0_wb: got we=%b wbst=%b ready=%b exp 0 0 1", rf_we, wb_stall, lu_res_ready);
      end
      do_reset();
      next_cycle(); id_rd = 5'd9;
      #1;
      tests_run++;
      if (hazard_stall !== 1'b0 || sb_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_clears_pending: got haz=%b err=%b exp 0 0", hazard_stall, sb_err);
      end
   endtask

   task automatic test_error_flag();
      next_cycle(); lu_issue = 1'b1; lu_issue_rd = 5'd4;
      next_cycle(); id_rs1 = 5'd4; lu_issue = 1'b1; lu_issue_rd = 5'd4;
      #1;
      tests_run++;
      if (hazard_stall !== 1'b1 || sb_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL err_before: got haz=%b err=%b exp 1 0", hazard_stall, sb_err);
      end
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         #1;
         tests_run++;
         if (sb_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_sticky_%0d: got %b exp 1", i, sb_err);
         end
      end
      next_cycle();
      reset = 1'b0;
      #1;
      tests_run++;
      if (sb_err !== 1'b0 || hazard_stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL err_reset: got err=%b haz=%b exp 0 0", sb_err, hazard_stall);
      end
      next_cycle();
      reset = 1'b1;
   endtask

   initial begin
      reset        = 1'b0;
      wb_valid     = 1'b0;
      wb_rd        = '0;
      wb_data      = '0;
      lu_issue     = 1'b0;
      lu_issue_rd  = '0;
      lu_res_valid = 1'b0;
      lu_res_rd    = '0;
      lu_res_data  = '0;
      id_rs1       = '0;
      id_rs2       = '0;
      id_rd        = '0;
      test_reset();
      test_basic_lu();
      test_starvation();
      test_full_buffer();
      test_x0_set_wins();
      test_error_flag();
      next_cycle();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/regfile_wb_sched.md
# regfile_wb_sched

- Write-port scheduler and scoreboard for the integer register file in the 5-stage core.
- Merges two write sources onto the single register-file write port: in-order WB-stage results and out-of-band results from the long-latency unit (mul/div).
- Buffers long-latency results until the port is free.
- Tracks registers with outstanding long-latency writes and produces the ID-stage hazard stall.

## Interface
- `LU_BUF_DEPTH`, default 2: long-latency result buffer entries; power of 2, ≥2.
- `STARVE_MAX`, default 4: consecutive cycles a non-empty buffer may lose the port before it takes the port by force.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low (0 = in reset).
- `wb_valid` in 1: WB stage has a result this cycle.
- `wb_rd` in 5: WB destination register.
- `wb_data` in 32: WB result data.
- `wb_stall` out 1: WB write not taken this cycle; the WB stage holds its contents and re-presents them next cycle.
- `lu_issue` in 1: ID issues an op to the long-latency unit this cycle.
- `lu_issue_rd` in 5: destination register of the issued op.
- `lu_res_valid` in 1: long-latency result offered.
- `lu_res_rd` in 5: destination register of the offered result.
- `lu_res_data` in 32: offered result data.
- `lu_res_ready` out 1: buffer can accept the offered result.
- `id_rs1`, `id_rs2`, `id_rd` in 5 each: register fields of the instruction in ID.
- `hazard_stall` out 1: ID must stall.
- `rf_we` out 1: write enable to the register file.
- `rf_rd` out 5: write address to the register file.
- `rf_wdata` out 32: write data to the register file.
- `sb_err` out 1: sticky scoreboard-protocol violation flag.

## Operation
- **Scoreboard `pending[31:1]`**
  - Set: bit r is set at the edge where `lu_issue` is high and `lu_issue_rd` = r ≠ 0.
  - Clear: bit r is cleared at the edge where a buffered result for r is written.
  - Set and clear of the same r in the same cycle: set wins.
  - x0 is never pending.
- **Hazard stall**
  - `hazard_stall` = `pending[id_rs1] | pending[id_rs2] | pending[id_rd]` (RAW and WAW).
  - An index of 0 contributes 0.
  - Combinational from registered state only.
- **Result buffer**
  - FIFO of {rd, data}; `lu_res_ready` = count < `LU_BUF_DEPTH`.
  - A push occurs when `lu_res_valid` and `lu_res_ready` are both high.
  - A push and a pop may happen in the same cycle. No push-to-pop bypass: data is writable no earlier than the cycle after it is accepted.
  - Read and write pointers wrap modulo depth; count has width clog2(DEPTH)+1.
- **Port arbitration** (combinational each cycle)
  - Forced slot: buffer non-empty and `starve_cnt` == `STARVE_MAX`. The buffer head is written and popped; `wb_stall` = `wb_valid`.
  - Otherwise, if `wb_valid`: the WB result is written and `wb_stall` = 0.
  - Otherwise, if buffer non-empty: the head is written and popped.
  - Otherwise: `rf_we` = 0.
  - `rf_we` is 0 whenever the selected rd is 0. A pop whose rd is 0 still occurs.
- **Starvation counter**
  - Increments, saturating at `STARVE_MAX`, when the buffer is non-empty and no pop occurs.
  - Resets to 0 on any pop or when the buffer is empty.
- **`sb_err`** is set, and held until reset, on any of:
  - `lu_issue` while `hazard_stall` is high;
  - `wb_valid` with `wb_rd` pending and `wb_stall` = 0;
  - a push whose rd is not pending.

## Timing
- **Reset** (`reset` = 0): `pending` = 0, buffer empty, `starve_cnt` = 0, `sb_err` = 0. Consequently:
  - `hazard_stall` = 0 and `lu_res_ready` = 1;
  - `rf_we` = `wb_valid && wb_rd != 0`, and `wb_stall` = 0.
  - A mid-operation reset discards buffered results with no write.
- **WB path:** zero latency; `rf_*` follows `wb_*` in the same cycle.
- **Long-latency path:**
  - Result accepted at edge t is written at the earliest in the cycle ending at edge t+1.
  - `pending` clears at that edge, and `hazard_stall` drops in the following cycle.
  - A register-file read in that cycle sees the new value.
- **Forced slot:** occurs at most once per `STARVE_MAX`+1 cycles per buffered entry. The worst-case wait of a head entry is `STARVE_MAX`+1 cycles.
- **Buffer full:** `lu_res_ready` = 0 and the offer must be held by the source. A pop in the same cycle does not raise `lu_res_ready` until the next cycle.

## Structure
- Shared package `core_pkg`: `REG_ADDR_W`=5, `XLEN`=32, and a packed typedef `wb_req_t` {rd, data} used for both write sources.
- Sub-module `lu_result_fifo`: parameterised depth; push/pop interface; outputs head, empty and full. It holds the only storage besides `pending` and `starve_cnt`.
- Top level holds the scoreboard, arbiter, starvation counter and error flag.

## Test plan
- **Reset.** Drive `reset`=0 with `wb_valid`=1, `wb_rd`=5. Expect `rf_we`=1, `rf_rd`=5, `hazard_stall`=0, `lu_res_ready`=1, `sb_err`=0.
- **Basic long-latency write.**
  - Issue to rd=7 → `hazard_stall`=1 for `id_rs1`=7.
  - Push {7, 0xDEADBEEF} with `wb_valid`=0 → next cycle `rf_we`=1, `rf_rd`=7, `rf_wdata`=0xDEADBEEF.
  - The following cycle `hazard_stall`=0.
- **Starvation.**
  - Push {3, 0x11} while `wb_valid` is held at 1 continuously.
  - Expect exactly `STARVE_MAX` (4) cycles of WB writes, then one cycle with `rf_rd`=3 and `wb_stall`=1.
  - Then the re-presented WB result is written.
- **Full buffer.**
  - Issue rd=1 and rd=2, then push both with `wb_valid`=1 → `lu_res_ready`=0.
  - A third offer is held; it is accepted only after the first pop.
- **x0 and set-wins.**
  - An issue with rd=0 sets no pending bit; a push with rd=0 pops with `rf_we`=0.
  - Issue rd=9 in the same cycle as a pop for rd=9 → `pending[9]` remains 1.
- **Error flag.** Issue rd=4 while `hazard_stall`=1 (`id_rs1` pending) → `sb_err`=1 and stays 1 until `reset`=0.
